// File: rtl/zet_wb_pkg.sv
// Shared types for the buffered Wishbone master.
// FSM state, posted-write payload and wait-counter sizing.
package zet_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  // Payload of one posted write; the address travels beside it.
  typedef struct packed {
    logic [15:0] dat;
    logic        byte_op;
    logic        m_io;
  } wdata_t;

  function automatic int wait_cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wb_wbuf.sv
// Posted-write FIFO: fall-through head, pushes refused while full.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_wbuf #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = (PW + 1)'(1);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full = (wr_ptr[PW] != rd_ptr[PW]) &&
                (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_master_buf.sv
// 16-bit Wishbone master with posted-write buffer, odd-address
// splitting into two bus cycles, and ack timeout/error abort.
module wb_master_buf
  import zet_wb_pkg::*;
#(
  parameter int AW         = 20,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cpu_memop,
  input  logic          cpu_m_io,
  input  logic          cpu_we_o,
  input  logic          cpu_byte_o,
  input  logic [AW-1:0] cpu_adr_o,
  input  logic [15:0]   cpu_dat_o,
  output logic [15:0]   cpu_dat_i,
  output logic          cpu_block,
  output logic          cpu_err,
  input  logic [15:0]   wb_dat_i,
  output logic [15:0]   wb_dat_o,
  output logic [AW-2:0] wb_adr_o,
  output logic          wb_we_o,
  output logic          wb_tga_o,
  output logic [1:0]    wb_sel_o,
  output logic          wb_stb_o,
  output logic          wb_cyc_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int CW = wait_cnt_w(TIMEOUT);
  localparam int EW = AW + $bits(wdata_t);

  state_t          state;
  state_t          state_nxt;
  logic            req;
  logic            rd_pend;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            load;
  logic            abort;
  logic            fin;
  logic            go_hi;
  logic            busy;
  logic            odd;
  logic            odd_word;
  logic            time_up;
  logic [AW-1:0]   act_adr;
  wdata_t          act;
  logic            act_we;
  logic [CW-1:0]   cnt;
  logic [15:0]     dat_r;
  logic            err_r;
  wdata_t          new_d;
  wdata_t          head_d;
  logic [AW-1:0]   head_adr;
  logic [EW-1:0]   fifo_din;
  logic [EW-1:0]   fifo_dout;

  assign req     = cpu_memop | cpu_m_io;
  assign rd_pend = req & ~cpu_we_o;
  assign push    = req & cpu_we_o & ~full;

  // Writes stall only on a full buffer; reads until their DONE cycle.
  assign cpu_block = cpu_we_o ? (req & full)
                              : (req & (state != S_DONE));

  always_comb begin
    new_d         = '0;
    new_d.dat     = cpu_dat_o;
    new_d.byte_op = cpu_byte_o;
    new_d.m_io    = cpu_m_io;
  end

  assign fifo_din           = {cpu_adr_o, new_d};
  assign {head_adr, head_d} = fifo_dout;

  wb_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .W     (EW)
  ) u_wbuf (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign busy     = (state == S_LO) | (state == S_HI);
  assign odd      = act_adr[0];
  assign odd_word = odd & ~act.byte_op;
  assign time_up  = (cnt == CW'(TIMEOUT - 1)) & ~wb_ack_i;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    abort     = 1'b0;
    fin       = 1'b0;
    go_hi     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty || rd_pend) begin
          state_nxt = S_LO;
          load      = 1'b1;
        end
      end
      S_LO, S_HI: begin
        if (wb_err_i || time_up) begin
          abort = 1'b1;
        end else if (wb_ack_i) begin
          if (state == S_LO && odd_word) go_hi = 1'b1;
          else                           fin   = 1'b1;
        end
        if (abort || fin) begin
          state_nxt = act_we ? S_IDLE : S_DONE;
          pop       = act_we;
        end else if (go_hi) begin
          state_nxt = S_HI;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Buffered writes win over a pending read when leaving IDLE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      act_adr <= '0;
      act     <= '0;
      act_we  <= 1'b0;
    end else if (load) begin
      if (!empty) begin
        act_adr <= head_adr;
        act     <= head_d;
        act_we  <= 1'b1;
      end else begin
        act_adr <= cpu_adr_o;
        act     <= new_d;
        act_we  <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               cnt <= '0;
    else if (load || go_hi)     cnt <= '0;
    else if (busy && !wb_ack_i) cnt <= cnt + CW'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dat_r <= '0;
    end else if (busy && !act_we) begin
      if (abort) begin
        dat_r <= 16'hFFFF;
      end else if (wb_ack_i) begin
        unique case (1'b1)
          ~odd & act.byte_op:
            dat_r <= {{8{wb_dat_i[7]}}, wb_dat_i[7:0]};
          ~odd & ~act.byte_op:
            dat_r <= wb_dat_i;
          odd & act.byte_op:
            dat_r <= {{8{wb_dat_i[15]}}, wb_dat_i[15:8]};
          odd_word & (state == S_LO):
            dat_r[7:0] <= wb_dat_i[15:8];
          odd_word & (state == S_HI):
            dat_r[15:8] <= wb_dat_i[7:0];
          default: dat_r <= dat_r;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) err_r <= 1'b0;
    else          err_r <= abort;
  end

  always_comb begin
    wb_sel_o = 2'b00;
    if (state == S_HI) begin
      wb_sel_o = 2'b01;
    end else if (state == S_LO) begin
      unique case (1'b1)
        odd:                 wb_sel_o = 2'b10;
        ~odd & act.byte_op:  wb_sel_o = 2'b01;
        ~odd & ~act.byte_op: wb_sel_o = 2'b11;
        default:             wb_sel_o = 2'b00;
      endcase
    end
  end

  assign wb_adr_o = (state == S_HI) ? act_adr[AW-1:1] + (AW - 1)'(1)
                                    : act_adr[AW-1:1];
  assign wb_dat_o = odd ? {act.dat[7:0], act.dat[15:8]} : act.dat;
  assign wb_we_o  = act_we;
  assign wb_tga_o = act.m_io;
  assign wb_stb_o = busy;
  assign wb_cyc_o = busy;

  assign cpu_dat_i = dat_r;
  assign cpu_err   = err_r;

endmodule

// File: tb/tb_wb_master_buf.sv
// Directed bench for wb_master_buf with a small Wishbone slave
// model whose ack and err are switched by the stimulus.
module tb_wb_master_buf;

  localparam int AW = 20;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          cpu_memop;
  logic          cpu_m_io;
  logic          cpu_we_o;
  logic          cpu_byte_o;
  logic [AW-1:0] cpu_adr_o;
  logic [15:0]   cpu_dat_o;
  logic [15:0]   cpu_dat_i;
  logic          cpu_block;
  logic          cpu_err;
  logic [15:0]   wb_dat_i;
  logic [15:0]   wb_dat_o;
  logic [AW-2:0] wb_adr_o;
  logic          wb_we_o;
  logic          wb_tga_o;
  logic [1:0]    wb_sel_o;
  logic          wb_stb_o;
  logic          wb_cyc_o;
  logic          wb_ack_i;
  logic          wb_err_i;

  logic ack_en;
  logic err_en;

  wb_master_buf #(
    .AW         (AW),
    .WBUF_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cpu_memop  (cpu_memop),
    .cpu_m_io   (cpu_m_io),
    .cpu_we_o   (cpu_we_o),
    .cpu_byte_o (cpu_byte_o),
    .cpu_adr_o  (cpu_adr_o),
    .cpu_dat_o  (cpu_dat_o),
    .cpu_dat_i  (cpu_dat_i),
    .cpu_block  (cpu_block),
    .cpu_err    (cpu_err),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_adr_o   (wb_adr_o),
    .wb_we_o    (wb_we_o),
    .wb_tga_o   (wb_tga_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [15:0] mem [0:(1<<19)-1];

  assign wb_ack_i = wb_stb_o & ack_en;
  assign wb_err_i = wb_stb_o & err_en;
  assign wb_dat_i = mem[wb_adr_o];

  typedef struct {
    logic [18:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic        tga;
    logic [15:0] dat;
  } xfer_t;

  xfer_t log_q[$];
  int    stb_n  = 0;
  int    err_n  = 0;
  int    done_n = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  always @(posedge wb_clk_i) begin
    if (wb_stb_o) stb_n <= stb_n + 1;
    if (cpu_err)  err_n <= err_n + 1;
    if (cpu_memop & ~cpu_we_o & ~cpu_block) done_n <= done_n + 1;
    if (wb_stb_o & wb_ack_i & ~wb_err_i) begin
      log_q.push_back('{wb_adr_o, wb_sel_o, wb_we_o, wb_tga_o, wb_dat_o});
      if (wb_we_o && wb_sel_o[0]) mem[wb_adr_o][7:0]  <= wb_dat_o[7:0];
      if (wb_we_o && wb_sel_o[1]) mem[wb_adr_o][15:8] <= wb_dat_o[15:8];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic bt, input logic io,
                        input logic [19:0] adr, input logic [15:0] dat,
                        output logic [15:0] rdata, output int waited);
    @(negedge wb_clk_i);
    cpu_memop  = ~io;
    cpu_m_io   = io;
    cpu_we_o   = we;
    cpu_byte_o = bt;
    cpu_adr_o  = adr;
    cpu_dat_o  = dat;
    waited     = 0;
    #1;
    while (cpu_block && waited < 100) begin
      @(negedge wb_clk_i);
      #1;
      waited++;
    end
    if (waited >= 100) check("op_bound", 32'(waited), 32'd0);
    rdata = cpu_dat_i;
    @(posedge wb_clk_i);
  endtask

  task automatic cpu_idle();
    @(negedge wb_clk_i);
    cpu_memop = 1'b0;
    cpu_m_io  = 1'b0;
    cpu_we_o  = 1'b0;
  endtask

  task automatic wait_log(input int base, input int n);
    int k = 0;
    while (log_q.size() < base + n && k < 200) begin
      @(posedge wb_clk_i);
      k++;
    end
    #1;
    check("log_count", 32'(log_q.size() - base), 32'(n));
  endtask

  initial begin
    logic [15:0] rd;
    int          w;
    int          lb;
    int          s0;
    int          e0;
    int          d0;
    logic [18:0] ea [3];
    logic [15:0] ed [3];

    ea[0] = 19'h00008; ea[1] = 19'h00010; ea[2] = 19'h00018;
    ed[0] = 16'hA001;  ed[1] = 16'hA002;  ed[2] = 16'hA003;

    wb_rst_i   = 1'b1;
    cpu_memop  = 1'b0;
    cpu_m_io   = 1'b0;
    cpu_we_o   = 1'b0;
    cpu_byte_o = 1'b0;
    cpu_adr_o  = '0;
    cpu_dat_o  = '0;
    ack_en     = 1'b1;
    err_en     = 1'b0;

    repeat (2) @(negedge wb_clk_i);
    #1;
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_err", 32'(cpu_err), 32'd0);
    check("rst_dat", 32'(cpu_dat_i), 32'd0);
    check("rst_block_noreq", 32'(cpu_block), 32'd0);
    cpu_memop = 1'b1;
    #1;
    check("rst_block_rd", 32'(cpu_block), 32'd1);
    cpu_we_o = 1'b1;
    #1;
    check("rst_block_wr", 32'(cpu_block), 32'd0);
    cpu_memop = 1'b0;
    cpu_we_o  = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // three back-to-back even word writes
    lb = log_q.size();
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b1, 1'b0, 1'b0, {ea[i], 1'b0}, ed[i], rd, w);
      check("b2b_nostall", 32'(w), 32'd0);
    end
    cpu_idle();
    wait_log(lb, 3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_adr", 32'(log_q[lb+i].adr), 32'(ea[i]));
      check("b2b_sel", 32'(log_q[lb+i].sel), 32'h3);
      check("b2b_dat", 32'(log_q[lb+i].dat), 32'(ed[i]));
    end

    // fill the buffer with the slave stalled
    ack_en = 1'b0;
    lb = log_q.size();
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, 1'b0, 1'b0, 20'h00100 + 20'(2 * i), 16'hB000 + 16'(i), rd, w);
      check("fill_nostall", 32'(w), 32'd0);
    end
    @(negedge wb_clk_i);
    cpu_memop = 1'b1;
    cpu_we_o  = 1'b1;
    cpu_adr_o = 20'h00108;
    cpu_dat_o = 16'hB004;
    #1;
    check("full_block", 32'(cpu_block), 32'd1);
    @(negedge wb_clk_i);
    #1;
    check("full_block_hold", 32'(cpu_block), 32'd1);
    ack_en = 1'b1;
    @(negedge wb_clk_i);
    ack_en = 1'b0;
    #1;
    check("full_release", 32'(cpu_block), 32'd0);
    @(posedge wb_clk_i);
    cpu_idle();
    ack_en = 1'b1;
    wait_log(lb, 5);
    repeat (6) @(posedge wb_clk_i);
    #1;
    check("fill_no_dup", 32'(log_q.size() - lb), 32'd5);
    check("fill_first_adr", 32'(log_q[lb].adr), 32'h80);
    check("fill_last_adr", 32'(log_q[lb+4].adr), 32'h84);
    check("fill_last_dat", 32'(log_q[lb+4].dat), 32'hB004);

    // odd word write then read of the same address
    lb = log_q.size();
    cpu_op(1'b1, 1'b0, 1'b0, 20'h00003, 16'h1234, rd, w);
    cpu_op(1'b0, 1'b0, 1'b0, 20'h00003, 16'h0000, rd, w);
    cpu_idle();
    check("odd_rd_data", 32'(rd), 32'h1234);
    wait_log(lb, 4);
    check("odd_w0_adr", 32'(log_q[lb].adr), 32'h1);
    check("odd_w0_sel", 32'(log_q[lb].sel), 32'h2);
    check("odd_w0_we", 32'(log_q[lb].we), 32'd1);
    check("odd_w0_dat", 32'(log_q[lb].dat), 32'h3412);
    check("odd_w1_adr", 32'(log_q[lb+1].adr), 32'h2);
    check("odd_w1_sel", 32'(log_q[lb+1].sel), 32'h1);
    check("odd_r0_we", 32'(log_q[lb+2].we), 32'd0);
    check("odd_r0_sel", 32'(log_q[lb+2].sel), 32'h2);
    check("odd_r1_adr", 32'(log_q[lb+3].adr), 32'h2);
    check("odd_r1_sel", 32'(log_q[lb+3].sel), 32'h1);

    // even byte I/O write carries the tag and low lane
    lb = log_q.size();
    cpu_op(1'b1, 1'b1, 1'b1, 20'h00040, 16'h00C5, rd, w);
    cpu_idle();
    wait_log(lb, 1);
    check("io_tga", 32'(log_q[lb].tga), 32'd1);
    check("io_sel", 32'(log_q[lb].sel), 32'h1);
    check("io_adr", 32'(log_q[lb].adr), 32'h20);

    // byte and word reads with sign extension
    @(negedge wb_clk_i);
    mem[19'h00002] <= 16'h80AB;
    lb = log_q.size();
    cpu_op(1'b0, 1'b1, 1'b0, 20'h00005, 16'h0000, rd, w);
    check("rd_odd_byte", 32'(rd), 32'hFF80);
    check("rd_odd_byte_sel", 32'(log_q[lb].sel), 32'h2);
    cpu_op(1'b0, 1'b1, 1'b0, 20'h00004, 16'h0000, rd, w);
    check("rd_even_byte", 32'(rd), 32'hFFAB);
    cpu_op(1'b0, 1'b0, 1'b0, 20'h00004, 16'h0000, rd, w);
    check("rd_even_word", 32'(rd), 32'h80AB);
    cpu_idle();

    // odd word read at the top wraps to word 0
    mem[19'h7FFFF] <= 16'h5600;
    mem[19'h00000] <= 16'h0078;
    lb = log_q.size();
    cpu_op(1'b0, 1'b0, 1'b0, 20'hFFFFF, 16'h0000, rd, w);
    cpu_idle();
    check("wrap_data", 32'(rd), 32'h7856);
    check("wrap_lo_adr", 32'(log_q[lb].adr), 32'h7FFFF);
    check("wrap_hi_adr", 32'(log_q[lb+1].adr), 32'h0);
    check("wrap_hi_sel", 32'(log_q[lb+1].sel), 32'h1);

    // read timeout with the slave silent
    ack_en = 1'b0;
    s0 = stb_n;
    e0 = err_n;
    d0 = done_n;
    cpu_op(1'b0, 1'b0, 1'b0, 20'h00100, 16'h0000, rd, w);
    cpu_idle();
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("to_data", 32'(rd), 32'hFFFF);
    check("to_stb_cycles", 32'(stb_n - s0), 32'd8);
    check("to_err_pulses", 32'(err_n - e0), 32'd1);
    check("to_done_cycles", 32'(done_n - d0), 32'd1);

    // err together with ack discards the write
    ack_en = 1'b1;
    err_en = 1'b1;
    mem[19'h00100] <= 16'h1111;
    e0 = err_n;
    cpu_op(1'b1, 1'b0, 1'b0, 20'h00200, 16'h5555, rd, w);
    cpu_idle();
    repeat (4) @(posedge wb_clk_i);
    #1;
    check("err_wr_pulse", 32'(err_n - e0), 32'd1);
    cpu_op(1'b0, 1'b0, 1'b0, 20'h00200, 16'h0000, rd, w);
    cpu_idle();
    check("err_rd_data", 32'(rd), 32'hFFFF);
    err_en = 1'b0;
    cpu_op(1'b0, 1'b0, 1'b0, 20'h00200, 16'h0000, rd, w);
    cpu_idle();
    check("err_wr_dropped", 32'(rd), 32'h1111);

    // asynchronous reset in the middle of a stalled read
    ack_en = 1'b0;
    @(negedge wb_clk_i);
    cpu_memop = 1'b1;
    cpu_we_o  = 1'b0;
    cpu_byte_o = 1'b0;
    cpu_adr_o = 20'h00300;
    repeat (3) @(negedge wb_clk_i);
    #1;
    check("mid_lo_stb", 32'(wb_stb_o), 32'd1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("arst_cyc", 32'(wb_cyc_o), 32'd0);
    check("arst_stb", 32'(wb_stb_o), 32'd0);
    check("arst_block", 32'(cpu_block), 32'd1);
    cpu_idle();
    wb_rst_i = 1'b0;
    #1;
    check("arst_idle_block", 32'(cpu_block), 32'd0);
    check("arst_dat", 32'(cpu_dat_i), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
